dlx_mem_access: RTL and testbench
=================================

# dlx_mem_access

Load/store controller between the DLX pipeline MEM stage and the word-wide `syncram` data memory. It accepts one load or store request at a time and drives the RAM's `cs/oe/we/addr/din` strobes. It performs read-modify-write for byte and halfword stores and returns sign- or zero-extended load data. Misaligned accesses are rejected with an error response and never reach the RAM.

## Interface
- No parameters; all address and data paths are fixed at 32 bits.

Ports:
- `clk`  in  1  system clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept a request this cycle
- `req_we`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as error)
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- `resp_valid`  out  1  one-cycle pulse: transaction complete
- `resp_err`  out  1  qualifies `resp_valid`: misaligned or reserved size
- `resp_rdata`  out  32  extended load data; 0 for stores and errors
- `ram_cs`, `ram_oe`, `ram_we`  out  1 each  RAM strobes
- `ram_addr`  out  32  word address `{addr[31:2],2'b00}`
- `ram_din`  out  32  RAM write data
- `ram_dout`  in  32  RAM read data, valid the cycle after `cs&oe` is sampled

## Operation
- Memory is big-endian. Byte offset 0 maps to bits [31:24] and offset 3 to [7:0]. Halfword offset 0 maps to [31:16] and offset 2 to [15:0].
- Accept condition: `req_valid & req_ready`. The unit latches `we`, `size`, `unsigned`, `addr` and `wdata`. Requests offered while busy are ignored and must be held by the pipeline, which stalls on `req_valid & ~req_ready`.
- FSM states: IDLE, RD, CAP, WR, RESP.
  - IDLE: `req_ready=1`. On accept:
    - Error request → RESP.
    - Word store → WR.
    - Any load, or a byte or halfword store → RD.
  - RD: `ram_cs=ram_oe=1`, `ram_we=0`, `ram_addr` from the latched address. Next state is CAP.
  - CAP: `ram_dout` is valid.
    - Load: extract the addressed lane, extend it, register it into `resp_rdata`, then go to RESP.
    - Sub-word store: merge `wdata` into the addressed lane of `ram_dout`, keep the other bytes, register the result as the write word, then go to WR.
  - WR: `ram_cs=ram_we=1`, `ram_oe=0`, `ram_din` = full `wdata` (word store) or the merged word. Next state is RESP.
  - RESP: `resp_valid=1`, `resp_err` as latched. Next state is IDLE.
- Strobes in other states: `ram_cs/oe/we` are 0 in IDLE, CAP and RESP. `ram_oe` and `ram_we` are never asserted together.
- Error rules (checked at accept):
  - Halfword with `addr[0]=1` is an error.
  - Word with `addr[1:0]!=0` is an error.
  - `size=11` is an error.
  - Error requests make no RAM access and return `resp_rdata=0`.
- `resp_rdata` holds its value until the next load completes or reset. It is cleared to 0 in CAP for stores.

## Timing
- Latency is measured from the accept cycle (cycle 0) to `resp_valid`:
  - Error: cycle 1.
  - Word store: cycle 2, with the write strobe in cycle 1.
  - Load: cycle 3, with the read strobe in cycle 1.
  - Sub-word store: cycle 4, with the read in cycle 1 and the write in cycle 3.
- Next accept: the earliest is the cycle after RESP. There is no back-to-back acceptance.
- Reset: while `rst=1` at a posedge, the next state is IDLE. Output values after reset:
  - `resp_valid=0`, `resp_err=0`, `resp_rdata=0`.
  - All RAM strobes 0, `ram_addr=0`, `ram_din=0`.
  - `req_ready` is forced 0 while `rst=1` and is 1 from the first cycle after release.
- Reset mid-operation: the transaction is abandoned and no `resp_valid` is produced.
  - If the unit is in WR during the reset edge, the RAM still samples `we` on that same edge, so the write commits. This is accepted behaviour.
  - If the unit is in RD during the reset edge, the RAM read occurs but its data is discarded.
- `req_valid` asserted during reset is not accepted.

## Test plan
- Load extension. Preload RAM[0x10]=0x8899AABB.
  - lb 0x11 → `resp_rdata=0xFFFFFF99`, `resp_valid` at cycle 3.
  - lbu 0x13 → 0x000000BB.
  - lh 0x10 → 0xFFFF8899.
  - lhu 0x12 → 0x0000AABB.
- Byte store RMW: sb 0x12, `wdata=0x00000055`.
  - Cycle 1: `cs/oe=1`, `ram_addr=0x10`.
  - Cycle 3: `cs/we=1`, `ram_din=0x889955BB`.
  - Cycle 4: `resp_valid`.
  - Follow-up lw 0x10 → 0x889955BB.
- Word store: sw 0x20, 0xDEADBEEF.
  - Cycle 1: `cs/we=1`, `din=0xDEADBEEF`.
  - Cycle 2: `resp_valid`.
  - lw 0x20 → 0xDEADBEEF.
- Misalignment:
  - lw 0x13 → `resp_valid`, `resp_err=1`, `rdata=0` at cycle 1, with `ram_cs` low throughout.
  - sh 0x11 → same behaviour.
  - `size=11` → same behaviour.
- Busy and stall: hold `req_valid` with a second request during a load → `req_ready=0` in cycles 1–3. The second request is accepted in cycle 4 and completes normally.
- Reset mid-load: assert `rst` during RD → no `resp_valid`, all strobes 0 the next cycle, `req_ready=1` the cycle after `rst` falls, and a fresh lw returns the correct data.

Source files
------------

// File: rtl/dlx_mem_access_if.sv
// Pipeline-side request/response bundle for the DLX MEM-stage load/store unit.
// The pipeline is the master; dlx_mem_access is the slave.
interface dlx_mem_access_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_err, resp_rdata
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, resp_valid, resp_err, resp_rdata
   );
endinterface

// File: rtl/dlx_mem_access.sv
// Load/store controller between the DLX MEM stage and a word-wide synchronous RAM.
// Big-endian lanes, read-modify-write for sub-word stores, misaligned requests rejected.
module dlx_mem_access (
   input  logic              clk,
   input  logic              rst,
   dlx_mem_access_if.slave   bus,
   output logic              ram_cs,
   output logic              ram_oe,
   output logic              ram_we,
   output logic [31:0]       ram_addr,
   output logic [31:0]       ram_din,
   input  logic [31:0]       ram_dout
);

   typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] merge_q, merge_d;

   logic        accept;
   logic        req_err;
   logic [7:0]  byte_lane;
   logic [15:0] half_lane;
   logic [31:0] load_ext;
   logic [31:0] merged;
   logic [4:0]  byte_sh;
   logic [4:0]  half_sh;

   assign bus.req_ready  = (state_q == IDLE) && !rst;
   assign accept         = bus.req_valid && bus.req_ready;
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_err   = (state_q == RESP) && err_q;
   assign bus.resp_rdata = rdata_q;
   assign ram_addr       = {addr_q[31:2], 2'b00};
   assign ram_din        = (size_q == SZ_WORD) ? wdata_q : merge_q;

   assign req_err = (bus.req_size == 2'b11)
                 || ((bus.req_size == SZ_HALF) && bus.req_addr[0])
                 || ((bus.req_size == SZ_WORD) && (bus.req_addr[1:0] != 2'b00));

   // Lane offset 0 is the most significant byte, hence the inverted offset shift.
   always_comb begin
      byte_sh   = {~addr_q[1:0], 3'b000};
      half_sh   = addr_q[1] ? 5'd0 : 5'd16;
      byte_lane = 8'(ram_dout >> byte_sh);
      half_lane = 16'(ram_dout >> half_sh);
      case (size_q)
         SZ_BYTE: begin
            load_ext = {{24{!uns_q && byte_lane[7]}}, byte_lane};
            merged   = (ram_dout & ~(32'h0000_00FF << byte_sh))
                     | ({24'h0, wdata_q[7:0]} << byte_sh);
         end
         SZ_HALF: begin
            load_ext = {{16{!uns_q && half_lane[15]}}, half_lane};
            merged   = (ram_dout & ~(32'h0000_FFFF << half_sh))
                     | ({16'h0, wdata_q[15:0]} << half_sh);
         end
         default: begin
            load_ext = ram_dout;
            merged   = wdata_q;
         end
      endcase
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      size_d  = size_q;
      uns_d   = uns_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      merge_d = merge_q;
      ram_cs  = 1'b0;
      ram_oe  = 1'b0;
      ram_we  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               we_d    = bus.req_we;
               size_d  = bus.req_size;
               uns_d   = bus.req_unsigned;
               addr_d  = bus.req_addr;
               wdata_d = bus.req_wdata;
               err_d   = req_err;
               if (req_err) begin
                  rdata_d = 32'h0;
                  state_d = RESP;
               end else if (bus.req_we && (bus.req_size == SZ_WORD)) begin
                  rdata_d = 32'h0;
                  state_d = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            ram_cs  = 1'b1;
            ram_oe  = 1'b1;
            state_d = CAP;
         end
         CAP: begin
            if (we_q) begin
               rdata_d = 32'h0;
               merge_d = merged;
               state_d = WR;
            end else begin
               rdata_d = load_ext;
               state_d = RESP;
            end
         end
         WR: begin
            ram_cs  = 1'b1;
            ram_we  = 1'b1;
            state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         err_q   <= 1'b0;
         rdata_q <= 32'h0;
         merge_q <= 32'h0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         merge_q <= merge_d;
      end
   end

endmodule

// File: tb/tb_dlx_mem_access.sv
// Directed bench for dlx_mem_access: a word RAM model behind the unit, one task per scenario.
// Cycle c is the c-th falling edge after the accept edge; accept cycle is 0.
module tb_dlx_mem_access;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_init = 1'b1;
   logic        ram_cs, ram_oe, ram_we;
   logic [31:0] ram_addr, ram_din;
   logic [31:0] ram_dout = 32'h0;
   logic [31:0] mem [0:63];

   int checks = 0;
   int fails  = 0;

   logic [7:1]  obs_rv, obs_err, obs_cs, obs_oe, obs_we;
   logic [31:0] obs_rdata [1:7];
   logic [31:0] obs_addr  [1:7];
   logic [31:0] obs_din   [1:7];
   logic        obs_ready0;

   dlx_mem_access_if bus ();

   dlx_mem_access dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
      .ram_cs   (ram_cs),
      .ram_oe   (ram_oe),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_din  (ram_din),
      .ram_dout (ram_dout)
   );

   always #5 clk = ~clk;

   // RAM model: write and read sampled on the same edge, read data registered.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
         mem[4] <= 32'h8899AABB;
      end else if (ram_cs && ram_we) begin
         mem[ram_addr[7:2]] <= ram_din;
      end
      if (ram_cs && ram_oe) ram_dout <= mem[ram_addr[7:2]];
   end

   task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      #1 obs_ready0 = bus.req_ready;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         obs_rv[c]    = bus.resp_valid;
         obs_err[c]   = bus.resp_err;
         obs_cs[c]    = ram_cs;
         obs_oe[c]    = ram_oe;
         obs_we[c]    = ram_we;
         obs_rdata[c] = bus.resp_rdata;
         obs_addr[c]  = ram_addr;
         obs_din[c]   = ram_din;
         if (c == 1) bus.req_valid = 1'b0;
      end
   endtask

   task automatic test_reset;
      logic [1:0] cs_seen;
      bus.req_valid    = 1'b1;
      bus.req_we       = 1'b1;
      bus.req_size     = 2'b10;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h30;
      bus.req_wdata    = 32'h12345678;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b expected 0", bus.req_ready); end
      checks++;
      if ({bus.resp_valid, bus.resp_err} !== 2'b00) begin fails++; $display("FAIL reset_resp: got %b expected 00", {bus.resp_valid, bus.resp_err}); end
      checks++;
      if (bus.resp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", bus.resp_rdata); end
      checks++;
      if ({ram_cs, ram_oe, ram_we} !== 3'b000) begin fails++; $display("FAIL reset_strobes: got %b expected 000", {ram_cs, ram_oe, ram_we}); end
      checks++;
      if ({ram_addr, ram_din} !== 64'h0) begin fails++; $display("FAIL reset_addr_din: got %h/%h expected 0/0", ram_addr, ram_din); end
      mem_init = 1'b0;
      rst = 1'b0;
      bus.req_valid = 1'b0;
      cs_seen = 2'b00;
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready: got %b expected 1", bus.req_ready); end
      cs_seen[0] = ram_cs;
      @(negedge clk);
      cs_seen[1] = ram_cs;
      checks++;
      if (cs_seen !== 2'b00) begin fails++; $display("FAIL reset_no_accept: cs %b expected 00", cs_seen); end
   endtask

   task automatic test_load_ext;
      logic [31:0] addrs [4] = '{32'h11, 32'h13, 32'h10, 32'h12};
      logic [1:0]  sizes [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
      logic        unss  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] exps  [4] = '{32'hFFFFFF99, 32'h000000BB, 32'hFFFF8899, 32'h0000AABB};
      for (int i = 0; i < 4; i++) begin
         run_req(1'b0, sizes[i], unss[i], addrs[i], 32'h0);
         checks++;
         if (obs_ready0 !== 1'b1) begin fails++; $display("FAIL load%0d_ready: got %b expected 1", i, obs_ready0); end
         checks++;
         if (obs_rv !== 7'b0000100) begin fails++; $display("FAIL load%0d_resp_timing: got %b expected 0000100", i, obs_rv); end
         checks++;
         if (obs_rdata[3] !== exps[i]) begin fails++; $display("FAIL load%0d_rdata: got %h expected %h", i, obs_rdata[3], exps[i]); end
         checks++;
         if ({obs_cs, obs_oe, obs_we} !== {7'b0000001, 7'b0000001, 7'b0000000}) begin
            fails++; $display("FAIL load%0d_strobes: cs %b oe %b we %b expected 0000001 0000001 0000000", i, obs_cs, obs_oe, obs_we);
         end
      end
   endtask

   task automatic test_byte_store;
      run_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h00000055);
      checks++;
      if ({obs_cs, obs_oe, obs_we} !== {7'b0000101, 7'b0000001, 7'b0000100}) begin
         fails++; $display("FAIL sb_strobes: cs %b oe %b we %b expected 0000101 0000001 0000100", obs_cs, obs_oe, obs_we);
      end
      checks++;
      if (obs_addr[1] !== 32'h10) begin fails++; $display("FAIL sb_read_addr: got %h expected 00000010", obs_addr[1]); end
      checks++;
      if (obs_din[3] !== 32'h889955BB) begin fails++; $display("FAIL sb_merge: got %h expected 889955bb", obs_din[3]); end
      checks++;
      if (obs_rv !== 7'b0001000 || obs_err[4] !== 1'b0 || obs_rdata[4] !== 32'h0) begin
         fails++; $display("FAIL sb_resp: rv %b err %b rdata %h expected 0001000 0 0", obs_rv, obs_err[4], obs_rdata[4]);
      end
      run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      checks++;
      if (obs_rdata[3] !== 32'h889955BB) begin fails++; $display("FAIL sb_readback: got %h expected 889955bb", obs_rdata[3]); end
   endtask

   task automatic test_word_store;
      run_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF);
      checks++;
      if ({obs_cs, obs_oe, obs_we} !== {7'b0000001, 7'b0000000, 7'b0000001}) begin
         fails++; $display("FAIL sw_strobes: cs %b oe %b we %b expected 0000001 0000000 0000001", obs_cs, obs_oe, obs_we);
      end
      checks++;
      if (obs_din[1] !== 32'hDEADBEEF || obs_addr[1] !== 32'h20) begin
         fails++; $display("FAIL sw_din_addr: got %h/%h expected deadbeef/00000020", obs_din[1], obs_addr[1]);
      end
      checks++;
      if (obs_rv !== 7'b0000010 || obs_rdata[2] !== 32'h0) begin
         fails++; $display("FAIL sw_resp: rv %b rdata %h expected 0000010 0", obs_rv, obs_rdata[2]);
      end
      run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
      checks++;
      if (obs_rdata[3] !== 32'hDEADBEEF) begin fails++; $display("FAIL sw_readback: got %h expected deadbeef", obs_rdata[3]); end
   endtask

   task automatic test_misaligned;
      logic        wes   [3] = '{1'b0, 1'b1, 1'b0};
      logic [1:0]  sizes [3] = '{2'b10, 2'b01, 2'b11};
      logic [31:0] addrs [3] = '{32'h13, 32'h11, 32'h10};
      for (int i = 0; i < 3; i++) begin
         run_req(wes[i], sizes[i], 1'b0, addrs[i], 32'hFFFFFFFF);
         checks++;
         if (obs_rv !== 7'b0000001 || obs_err !== 7'b0000001) begin
            fails++; $display("FAIL err%0d_resp: rv %b err %b expected 0000001 0000001", i, obs_rv, obs_err);
         end
         checks++;
         if (obs_rdata[1] !== 32'h0) begin fails++; $display("FAIL err%0d_rdata: got %h expected 0", i, obs_rdata[1]); end
         checks++;
         if (obs_cs !== 7'b0000000) begin fails++; $display("FAIL err%0d_cs: got %b expected 0000000", i, obs_cs); end
      end
   endtask

   task automatic test_back_to_back;
      logic [8:1]  ready_vec;
      logic [8:1]  rv_vec;
      logic [31:0] rd3, rd7;
      @(negedge clk);
      bus.req_valid    = 1'b1;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'b10;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h10;
      rd3 = 32'h0;
      rd7 = 32'h0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         ready_vec[c] = bus.req_ready;
         rv_vec[c]    = bus.resp_valid;
         if (c == 3) rd3 = bus.resp_rdata;
         if (c == 7) rd7 = bus.resp_rdata;
         if (c == 1) begin
            bus.req_size     = 2'b01;
            bus.req_unsigned = 1'b1;
            bus.req_addr     = 32'h12;
         end
         if (c == 5) bus.req_valid = 1'b0;
      end
      checks++;
      if (ready_vec !== 8'b10001000) begin fails++; $display("FAIL stall_ready: got %b expected 10001000", ready_vec); end
      checks++;
      if (rv_vec !== 8'b01000100) begin fails++; $display("FAIL stall_resp: got %b expected 01000100", rv_vec); end
      checks++;
      if (rd3 !== 32'h889955BB || rd7 !== 32'h000055BB) begin
         fails++; $display("FAIL stall_rdata: got %h/%h expected 889955bb/000055bb", rd3, rd7);
      end
   endtask

   task automatic test_reset_mid_load;
      logic rv_any;
      @(negedge clk);
      bus.req_valid    = 1'b1;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'b10;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h20;
      @(negedge clk);
      bus.req_valid = 1'b0;
      checks++;
      if ({ram_cs, ram_oe} !== 2'b11) begin fails++; $display("FAIL rstmid_in_rd: got %b expected 11", {ram_cs, ram_oe}); end
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({ram_cs, ram_oe, ram_we, bus.resp_valid, bus.req_ready} !== 5'b00000) begin
         fails++; $display("FAIL rstmid_quiet: got %b expected 00000", {ram_cs, ram_oe, ram_we, bus.resp_valid, bus.req_ready});
      end
      checks++;
      if (bus.resp_rdata !== 32'h0) begin fails++; $display("FAIL rstmid_rdata: got %h expected 0", bus.resp_rdata); end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready: got %b expected 1", bus.req_ready); end
      rv_any = bus.resp_valid;
      repeat (3) begin
         @(negedge clk);
         rv_any = rv_any | bus.resp_valid;
      end
      checks++;
      if (rv_any !== 1'b0) begin fails++; $display("FAIL rstmid_no_resp: got %b expected 0", rv_any); end
      run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
      checks++;
      if (obs_rv !== 7'b0000100 || obs_rdata[3] !== 32'hDEADBEEF) begin
         fails++; $display("FAIL rstmid_reload: rv %b rdata %h expected 0000100 deadbeef", obs_rv, obs_rdata[3]);
      end
   endtask

   initial begin
      bus.req_valid    = 1'b0;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'b00;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h0;
      bus.req_wdata    = 32'h0;
      test_reset();
      test_load_ext();
      test_byte_store();
      test_word_store();
      test_misaligned();
      test_back_to_back();
      test_reset_mid_load();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
